// File: rtl/rx_iod_align_pkg.sv
// Shared definitions for the RX IOD word aligner and the transmit-side
// training pattern generator.
package rx_iod_align_pkg;

   // Deserialized word width of the 4:1 DDR lane IOD.
   localparam int RX_DATA_WIDTH = 4;

   // Word the far-end transmitter sends after reset while training.
   localparam logic [RX_DATA_WIDTH-1:0] RX_TRAIN_PATTERN = 4'b0011;

   // Aligner states. The S_ prefix keeps SLIP_WAIT free for the timer parameter.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SETTLE    = 3'd1,
      S_COMPARE   = 3'd2,
      S_SLIP      = 3'd3,
      S_SLIP_WAIT = 3'd4,
      S_LOCKED    = 3'd5,
      S_FAIL      = 3'd6
   } align_state_t;

endpackage

// File: rtl/rx_iod_align_cnt.sv
// Saturating down-counter with load and synchronous clear. Used as the
// settle, slip-wait and match timers of the word aligner.
module rx_iod_align_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load wins over decrement; decrement stops at zero instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= '0;
      else if (clr)             cnt <= '0;
      else if (load)            cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rx_iod_word_align.sv
// Receive-side word aligner for the 4:1 DDR IOD lanes. Compares the
// registered RX word against the training pattern, pulses RX_BIT_SLIP
// until the boundary matches, then reports lock (or failure) and passes
// aligned data through.
module rx_iod_word_align
   import rx_iod_align_pkg::*;
#(
   parameter int                    DATA_WIDTH    = RX_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = RX_TRAIN_PATTERN,
   parameter int                    SETTLE_CYCLES = 16,
   parameter int                    MATCH_COUNT   = 8,
   parameter int                    SLIP_WAIT     = 4,
   parameter int                    MAX_SLIPS     = 8
) (
   input  logic                  FAB_CLK,
   input  logic                  ARST_N,
   input  logic                  RX_SYNC_RST,
   input  logic                  TRAIN_START,
   input  logic [DATA_WIDTH-1:0] RX_DATA,
   output logic                  RX_BIT_SLIP,
   output logic                  ALIGN_DONE,
   output logic                  ALIGN_ERR,
   output logic [3:0]            SLIP_CNT,
   output logic [DATA_WIDTH-1:0] RX_DATA_OUT,
   output logic                  RX_DATA_VALID
);

   // Timers are loaded with N-1 so that a state lasts exactly N cycles.
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] MATCH_LD  = 8'(MATCH_COUNT - 1);
   localparam logic [7:0] WAIT_LD   = 8'(SLIP_WAIT - 1);
   localparam logic [3:0] SLIP_MAX  = 4'(MAX_SLIPS);

   align_state_t          state, next_state;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  match;
   logic                  settle_zero, match_zero, wait_zero;

   // Input stage: every compare and the user data path see this register.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N)          data_q <= '0;
      else if (RX_SYNC_RST) data_q <= '0;
      else                  data_q <= RX_DATA;
   end

   assign match       = (data_q == TRAIN_PATTERN);
   assign RX_DATA_OUT = data_q;

   // Settle timer: armed by TRAIN_START, runs while in SETTLE.
   rx_iod_align_cnt #(.W(8)) u_settle_cnt (
      .clk      (FAB_CLK),
      .rst_n    (ARST_N),
      .clr      (RX_SYNC_RST),
      .load     (TRAIN_START),
      .en       (state == S_SETTLE),
      .load_val (SETTLE_LD),
      .zero     (settle_zero)
   );

   // Match timer: reloaded on every entry to COMPARE, steps on each match.
   rx_iod_align_cnt #(.W(8)) u_match_cnt (
      .clk      (FAB_CLK),
      .rst_n    (ARST_N),
      .clr      (RX_SYNC_RST),
      .load     ((next_state == S_COMPARE) && (state != S_COMPARE)),
      .en       ((state == S_COMPARE) && match),
      .load_val (MATCH_LD),
      .zero     (match_zero)
   );

   // Slip-wait timer: armed during the slip pulse, covers the IOD slip latency.
   rx_iod_align_cnt #(.W(8)) u_wait_cnt (
      .clk      (FAB_CLK),
      .rst_n    (ARST_N),
      .clr      (RX_SYNC_RST),
      .load     (state == S_SLIP),
      .en       (state == S_SLIP_WAIT),
      .load_val (WAIT_LD),
      .zero     (wait_zero)
   );

   // State register; synchronous restart beats everything else.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N)          state <= S_IDLE;
      else if (RX_SYNC_RST) state <= S_IDLE;
      else                  state <= next_state;
   end

   // Next-state logic; TRAIN_START overrides any other transition.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      next_state = S_IDLE;
         S_SETTLE:    if (settle_zero) next_state = S_COMPARE;
         S_COMPARE: begin
            if (!match)          next_state = (SLIP_CNT < SLIP_MAX) ? S_SLIP : S_FAIL;
            else if (match_zero) next_state = S_LOCKED;
         end
         S_SLIP:      next_state = S_SLIP_WAIT;
         S_SLIP_WAIT: if (wait_zero) next_state = S_COMPARE;
         S_LOCKED:    next_state = S_LOCKED;
         S_FAIL:      next_state = S_FAIL;
         default:     next_state = S_IDLE;
      endcase
      if (TRAIN_START) next_state = S_SETTLE;
   end

   // Registered outputs decoded from the next state so they track the state register.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         RX_BIT_SLIP   <= 1'b0;
         ALIGN_DONE    <= 1'b0;
         ALIGN_ERR     <= 1'b0;
         RX_DATA_VALID <= 1'b0;
         SLIP_CNT      <= 4'd0;
      end else if (RX_SYNC_RST) begin
         RX_BIT_SLIP   <= 1'b0;
         ALIGN_DONE    <= 1'b0;
         ALIGN_ERR     <= 1'b0;
         RX_DATA_VALID <= 1'b0;
         SLIP_CNT      <= 4'd0;
      end else begin
         RX_BIT_SLIP   <= (next_state == S_SLIP);
         ALIGN_DONE    <= (next_state == S_LOCKED);
         ALIGN_ERR     <= (next_state == S_FAIL);
         RX_DATA_VALID <= (next_state == S_LOCKED);
         if (TRAIN_START)
            SLIP_CNT <= 4'd0;
         else if (next_state == S_SLIP && SLIP_CNT != 4'hF)
            SLIP_CNT <= SLIP_CNT + 4'd1;
      end
   end

endmodule
